// File: rtl/led_matrix_scan.sv
// 8x8 LED matrix back end: double-buffered framebuffer with frame-boundary swap and row scanner.
// Optional per-dwell output blanking is enabled by defining LED_SCAN_BLANK_EN.
module led_matrix_scan #(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 4,
  localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [RW-1:0]   wr_row,
  input  logic [COLS-1:0] wr_data,
  input  logic            clr,
  input  logic            swap_req,
  output logic            swap_pending,
  output logic            swap_done,
  output logic            frame_tick,
  output logic [ROWS-1:0] led_row,
  output logic [COLS-1:0] led_col
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK_LIM = DW'(BLANK_CYCLES);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [RW:0]   ROW_COUNT = (RW + 1)'(ROWS);

  logic [COLS-1:0] back_r     [ROWS];
  logic [COLS-1:0] front_r    [ROWS];
  logic [COLS-1:0] back_nxt_s [ROWS];
  logic [DW-1:0]   div_r;
  logic [RW-1:0]   row_idx_r;
  logic            pending_r;

  logic            boundary_s;
  logic            do_swap_s;
  logic            wr_ok_s;
  logic            blank_en_s;
  logic            blank_s;
  logic [ROWS-1:0] row_sel_s;
  logic [COLS-1:0] col_sel_s;

  assign swap_pending = pending_r;

  // Frame boundary and swap decision for the current cycle
  always_comb begin
    boundary_s = (row_idx_r == ROW_LAST) && (div_r == DIV_LAST);
    do_swap_s  = boundary_s && (pending_r || swap_req);
    wr_ok_s    = ({1'b0, wr_row} < ROW_COUNT);
  end

  // Next back-buffer contents: a write wins over a same-cycle clear
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      if (wr_en && wr_ok_s && (wr_row == RW'(r))) begin
        back_nxt_s[r] = wr_data;
      end else if (clr) begin
        back_nxt_s[r] = {COLS{1'b0}};
      end else begin
        back_nxt_s[r] = back_r[r];
      end
    end
  end

  // Dwell divider and row index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r     <= {DW{1'b0}};
      row_idx_r <= {RW{1'b0}};
    end else if (div_r == DIV_LAST) begin
      div_r     <= {DW{1'b0}};
      row_idx_r <= (row_idx_r == ROW_LAST) ? {RW{1'b0}} : row_idx_r + 1'b1;
    end else begin
      div_r     <= div_r + 1'b1;
    end
  end

  // Back/front buffers and swap request latch; front copies the pre-edge back image
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) begin
        back_r[r]  <= {COLS{1'b0}};
        front_r[r] <= {COLS{1'b0}};
      end
      pending_r <= 1'b0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        back_r[r] <= back_nxt_s[r];
        if (do_swap_s) begin
          front_r[r] <= back_r[r];
        end
      end
      pending_r <= boundary_s ? 1'b0 : (pending_r | swap_req);
    end
  end

  // Row select, column data and blanking qualifier for the next output cycle
  always_comb begin
`ifdef LED_SCAN_BLANK_EN
    blank_en_s = 1'b1;
`else
    blank_en_s = 1'b0;
`endif
    blank_s = blank_en_s && (div_r < BLANK_LIM);
    for (int r = 0; r < ROWS; r++) begin
      row_sel_s[r] = (row_idx_r == RW'(r));
    end
    col_sel_s = front_r[row_idx_r];
  end

  // Registered display outputs and pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_row    <= {ROWS{1'b0}};
      led_col    <= {COLS{1'b0}};
      frame_tick <= 1'b0;
      swap_done  <= 1'b0;
    end else begin
      led_row    <= blank_s ? {ROWS{1'b0}} : row_sel_s;
      led_col    <= blank_s ? {COLS{1'b0}} : col_sel_s;
      frame_tick <= boundary_s;
      swap_done  <= do_swap_s;
    end
  end

endmodule
